wb_stage: RTL and testbench

//  Write-back stage. Consumes the registered MEM/WB bundle (W_D, W_pc_4, W_RW, W_jal, W_RegWrite, syscall, W_mfc0).

---
 rtl/wb_stage_if.sv | 21 ++
 rtl/wb_stage.sv | 128 ++++++++++++
 tb/tb_wb_stage.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_stage_if.sv
// ============================================================================
// Module      : wb_stage_if
// Description : MEM/WB pipeline bundle delivered to the write-back stage.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface wb_stage_if;
    logic [31:0] W_D;
    logic [31:0] W_pc_4;
    logic [4:0]  W_RW;
    logic        W_jal;
    logic        W_RegWrite;
    logic        syscall;
    logic        W_mfc0;

    modport master (output W_D, W_pc_4, W_RW, W_jal, W_RegWrite, syscall, W_mfc0);
    modport slave  (input  W_D, W_pc_4, W_RW, W_jal, W_RegWrite, syscall, W_mfc0);
endinterface

`default_nettype wire

// File: rtl/wb_stage.sv
// ============================================================================
// Module      : wb_stage
// Description : Write-back stage: regfile write port, WB->ID bypass register,
//               syscall print / halt handling. Optional retire counter is
//               enabled by defining WB_STATS_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_stage #(
    parameter logic [31:0] HALT_CODE = 32'd10,
    parameter int          CNT_W     = 32
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    wb_stage_if.slave             mw,
    input  wire logic [31:0]      cp0_rdata,
    input  wire logic [31:0]      v0_val,
    input  wire logic [31:0]      a0_val,
    output logic                  rf_we,
    output logic [4:0]            rf_waddr,
    output logic [31:0]           rf_wdata,
    output logic                  fwd_valid,
    output logic [4:0]            fwd_addr,
    output logic [31:0]           fwd_data,
    output logic                  disp_we,
    output logic [31:0]           disp_data,
    output logic                  halt,
    output logic                  halted,
    output logic [CNT_W-1:0]      retire_cnt
);

    localparam logic [1:0] c_S_RUN      = 2'd0;
    localparam logic [1:0] c_S_HALT_REQ = 2'd1;
    localparam logic [1:0] c_S_HALTED   = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic       w_run;
    logic       w_halt_sys;
    logic       w_print_sys;

    assign w_run       = (r_state == c_S_RUN);
    assign w_halt_sys  = mw.syscall && (v0_val == HALT_CODE);
    assign w_print_sys = mw.syscall && (v0_val != HALT_CODE);

    assign rf_waddr = mw.W_jal ? 5'd31 : mw.W_RW;
    assign rf_wdata = mw.W_jal  ? mw.W_pc_4 :
                      mw.W_mfc0 ? cp0_rdata : mw.W_D;
    // rst_n gates the enable so no write escapes while reset is held
    assign rf_we    = rst_n && mw.W_RegWrite && (rf_waddr != 5'd0) && w_run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_S_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_RUN:      if (w_halt_sys) w_next_state = c_S_HALT_REQ;
            c_S_HALT_REQ: w_next_state = c_S_HALTED;
            c_S_HALTED:   w_next_state = c_S_HALTED;
            default:      w_next_state = c_S_RUN;
        endcase
    end

    always_comb begin
        halt   = 1'b0;
        halted = 1'b0;
        case (r_state)
            c_S_HALT_REQ: halt = 1'b1;
            c_S_HALTED: begin
                halt   = 1'b1;
                halted = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_valid <= 1'b0;
            fwd_addr  <= 5'd0;
            fwd_data  <= 32'd0;
        end else if (rf_we) begin
            fwd_valid <= 1'b1;
            fwd_addr  <= rf_waddr;
            fwd_data  <= rf_wdata;
        end else begin
            fwd_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_we   <= 1'b0;
            disp_data <= 32'd0;
        end else begin
            disp_we <= w_run && w_print_sys;
            if (w_run && w_print_sys) begin
                disp_data <= a0_val;
            end
        end
    end

`ifdef WB_STATS_EN
    logic [CNT_W-1:0] r_retire_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retire_cnt <= '0;
        end else if (w_run && (mw.W_RegWrite || mw.syscall) && (r_retire_cnt != {CNT_W{1'b1}})) begin
            r_retire_cnt <= r_retire_cnt + CNT_W'(1);
        end
    end

    assign retire_cnt = r_retire_cnt;
`else
    assign retire_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_stage.sv
// ============================================================================
// Module      : tb_wb_stage
// Description : Self-checking bench for wb_stage (directed + random cycles).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wb_stage;
    localparam int          c_CNT_W = 4;
    localparam logic [31:0] c_HALT  = 32'd10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [31:0] cp0_rdata = '0, v0_val = '0, a0_val = '0;
    logic        rf_we, fwd_valid, disp_we, halt, halted;
    logic [4:0]  rf_waddr, fwd_addr;
    logic [31:0] rf_wdata, fwd_data, disp_data;
    logic [c_CNT_W-1:0] retire_cnt;

    int checks = 0;
    int failures = 0;

    // reference model state
    int          m_halt_age;   // -1 running, else edges since halt was accepted
    logic        m_fv;
    logic [4:0]  m_fa;
    logic [31:0] m_fd;
    logic        m_dwe;
    logic [31:0] m_dd;
    int          m_cnt;

    wb_stage_if bus ();

    wb_stage #(.HALT_CODE(c_HALT), .CNT_W(c_CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .mw(bus.slave),
        .cp0_rdata(cp0_rdata), .v0_val(v0_val), .a0_val(a0_val),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .disp_we(disp_we), .disp_data(disp_data),
        .halt(halt), .halted(halted), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] exp_waddr();
        return bus.W_jal ? 5'd31 : bus.W_RW;
    endfunction

    function automatic logic [31:0] exp_wdata();
        if (bus.W_jal)  return bus.W_pc_4;
        if (bus.W_mfc0) return cp0_rdata;
        return bus.W_D;
    endfunction

    function automatic logic exp_we();
        return rst_n && bus.W_RegWrite && (exp_waddr() != 5'd0) && (m_halt_age < 0);
    endfunction

    function automatic logic [31:0] exp_cnt();
`ifdef WB_STATS_EN
        return 32'(m_cnt);
`else
        return 32'd0;
`endif
    endfunction

    task automatic check_regs();
        chk("fwd_valid", {31'd0, fwd_valid}, {31'd0, m_fv});
        chk("fwd_addr", {27'd0, fwd_addr}, {27'd0, m_fa});
        chk("fwd_data", fwd_data, m_fd);
        chk("disp_we", {31'd0, disp_we}, {31'd0, m_dwe});
        chk("disp_data", disp_data, m_dd);
        chk("halt", {31'd0, halt}, {31'd0, m_halt_age >= 0});
        chk("halted", {31'd0, halted}, {31'd0, m_halt_age >= 1});
        chk("retire_cnt", 32'(retire_cnt), exp_cnt());
    endtask

    task automatic model_reset();
        m_halt_age = -1;
        m_fv = 0; m_fa = '0; m_fd = '0; m_dwe = 0; m_dd = '0; m_cnt = 0;
    endtask

    // Assert reset asynchronously mid-cycle, check it took effect, release at negedge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
        check_regs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock: check comb outputs, advance model across the edge, check registers.
    task automatic cycle();
        logic        we, running, sys_halt, sys_print;
        logic [4:0]  wa;
        logic [31:0] wd;
        #1;
        we = exp_we(); wa = exp_waddr(); wd = exp_wdata();
        chk("rf_we", {31'd0, rf_we}, {31'd0, we});
        chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, wa});
        chk("rf_wdata", rf_wdata, wd);
        running   = (m_halt_age < 0);
        sys_halt  = bus.syscall && (v0_val == c_HALT);
        sys_print = bus.syscall && (v0_val != c_HALT);
        @(posedge clk);
        m_fv = we;
        if (we) begin m_fa = wa; m_fd = wd; end
        m_dwe = running && sys_print;
        if (m_dwe) m_dd = a0_val;
        if (running && (bus.W_RegWrite || bus.syscall) && m_cnt < (1 << c_CNT_W) - 1) m_cnt++;
        if (running && sys_halt) m_halt_age = 0;
        else if (!running) m_halt_age++;
        #1;
        check_regs();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.W_D = '0; bus.W_pc_4 = '0; bus.W_RW = '0; bus.W_jal = 0;
        bus.W_RegWrite = 0; bus.syscall = 0; bus.W_mfc0 = 0;
        cp0_rdata = '0; v0_val = '0; a0_val = '0;
    endtask

    initial begin
        idle_inputs();
        model_reset();
        @(negedge clk);
        do_reset();

        // register write then bypass
        bus.W_RegWrite = 1; bus.W_RW = 5'd5; bus.W_D = 32'hDEADBEEF;
        cycle();
        // jal priority, then mfc0
        bus.W_jal = 1; bus.W_pc_4 = 32'h3004; bus.W_mfc0 = 1; cp0_rdata = 32'h55;
        cycle();
        bus.W_jal = 0;
        cycle();
        // write to $0 suppressed
        bus.W_mfc0 = 0; bus.W_RW = 5'd0;
        cycle();
        // back-to-back prints
        idle_inputs();
        bus.syscall = 1; v0_val = 32'd1; a0_val = 32'h1234;
        cycle(); cycle();
        bus.syscall = 0;
        cycle();

        // random traffic with occasional resets
        for (int i = 0; i < 300; i++) begin
            bus.W_D = $urandom; bus.W_pc_4 = $urandom; cp0_rdata = $urandom;
            bus.W_RW = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            bus.W_jal = ($urandom_range(0, 5) == 0);
            bus.W_mfc0 = ($urandom_range(0, 4) == 0);
            bus.W_RegWrite = $urandom_range(0, 1) != 0;
            bus.syscall = ($urandom_range(0, 4) == 0);
            case ($urandom_range(0, 7))
                0:       v0_val = c_HALT;
                1, 2:    v0_val = $urandom;
                default: v0_val = 32'($urandom_range(0, 9));
            endcase
            a0_val = $urandom;
            if (i % 37 == 36) do_reset();
            else cycle();
        end

        // halt sequence, writes blocked, then reset mid-HALTED
        idle_inputs();
        do_reset();
        bus.syscall = 1; v0_val = c_HALT;
        cycle();
        bus.syscall = 0; bus.W_RegWrite = 1; bus.W_RW = 5'd8; bus.W_D = 32'h77;
        cycle(); cycle();
        bus.syscall = 1; v0_val = 32'd1; a0_val = 32'h99;
        cycle();
        do_reset();
        // reset in the middle of HALT_REQ
        idle_inputs();
        bus.syscall = 1; v0_val = c_HALT;
        cycle();
        do_reset();

        // retire counter saturation
        idle_inputs();
        bus.W_RegWrite = 1; bus.W_RW = 5'd3;
        for (int i = 0; i < 20; i++) cycle();
        chk("retire_sat", 32'(retire_cnt), exp_cnt());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

`default_nettype wire
